// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding, iteration count and small op-decoding helpers.
package mdu_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FINAL = 2'b10
    } mdu_state_e;

    // MULT and DIV are the signed variants; bit 0 clear in their encoding.
    function automatic logic op_is_signed(input mdu_op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
// Groups the request, MTHI/MTLO and result signals of the multiply/divide unit.
//   master : issues operations and HI/LO writes (execute-stage control / bench)
//   slave  : the multiply/divide unit itself
// Signals: start, op, rs_val, rt_val, hi_we, lo_we, wdata (master -> slave);
//          busy, done, hi, lo (slave -> master).
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    import mdu_pkg::*;

    logic             start;
    mdu_op_e          op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix
// Combinational result correction applied in the FINAL state.
// Ports:
//   is_div   : latched op is DIV/DIVU
//   div_zero : latched divisor magnitude is zero
//   neg_res  : product / quotient must be negated (operand signs differ, signed op)
//   neg_rem  : remainder must be negated (dividend negative, signed divide)
//   mag      : unsigned iteration result; product, or {remainder, quotient}
//   a_mag    : latched magnitude of rs_val
//   hi_res   : value to load into HI
//   lo_res   : value to load into LO
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic               div_zero,
    input  logic               neg_res,
    input  logic               neg_rem,
    input  logic [2*WIDTH-1:0] mag,
    input  logic [WIDTH-1:0]   a_mag,
    output logic [WIDTH-1:0]   hi_res,
    output logic [WIDTH-1:0]   lo_res
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dividend;

    // For a signed op neg_rem is exactly the sign of rs_val, so re-negating the
    // magnitude recovers the original operand without storing it separately
    // (0x80000000 maps onto itself, which is also what we want).
    always_comb begin
        prod     = neg_res ? -mag : mag;
        quot     = mag[WIDTH-1:0];
        rem      = mag[2*WIDTH-1:WIDTH];
        dividend = neg_rem ? -a_mag : a_mag;

        hi_res = prod[2*WIDTH-1:WIDTH];
        lo_res = prod[WIDTH-1:0];

        if (is_div) begin
            if (div_zero) begin
                hi_res = dividend;
                lo_res = '1;
            end else begin
                // Negating 0x80000000 wraps back to 0x80000000, which gives the
                // required DIV 0x80000000 / -1 result with no special case.
                lo_res = neg_res ? -quot : quot;
                hi_res = neg_rem ? -rem : rem;
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-low; clears all state
//   bus   : mul_div_unit_if.slave
//           start/op/rs_val/rt_val request an operation (taken only when idle),
//           hi_we/lo_we/wdata perform MTHI/MTLO when idle and not starting,
//           busy/done report progress, hi/lo are the registered HI/LO values.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic            clk,
    input  logic            reset,
    mul_div_unit_if.slave   bus
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    mdu_state_e         state;
    logic [CNT_W-1:0]   cnt;
    mdu_op_e            op_q;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] div_next;

    logic [WIDTH-1:0]   hi_res;
    logic [WIDTH-1:0]   lo_res;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Operand magnitudes as presented on the accepting edge; unsigned ops pass
    // the raw operands through.
    always_comb begin
        rs_neg = op_is_signed(bus.op) & bus.rs_val[WIDTH-1];
        rt_neg = op_is_signed(bus.op) & bus.rt_val[WIDTH-1];
        rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
        rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;
    end

    // One iteration of each algorithm.
    // Multiply: acc = {partial product, remaining multiplier bits}; add the
    // multiplicand into the upper half when the current multiplier bit is set,
    // then shift right so the carry lands in the top bit.
    // Divide: acc = {partial remainder, remaining dividend bits}; shift the next
    // dividend bit into the remainder, subtract the divisor when it fits, and
    // shift the quotient bit into the vacated low bit.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};

        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, b_mag});
        div_diff  = div_shift - {1'b0, b_mag};
        div_next  = {(div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_fits};
    end

    mdu_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .is_div   (op_is_div(op_q)),
        .div_zero (b_mag == '0),
        .neg_res  (sign_a ^ sign_b),
        .neg_rem  (sign_a),
        .mag      (acc),
        .a_mag    (a_mag),
        .hi_res   (hi_res),
        .lo_res   (lo_res)
    );

    // Control FSM plus all datapath registers. The accumulator is loaded with
    // the operand that gets shifted out (multiplier or dividend) in its low
    // half and a cleared upper half. A new request takes priority over
    // MTHI/MTLO in the same idle cycle; both are ignored while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= MDU_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            acc    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        sign_a <= rs_neg;
                        sign_b <= rt_neg;
                        a_mag  <= rs_mag;
                        b_mag  <= rt_mag;
                        acc    <= {{WIDTH{1'b0}}, (op_is_div(bus.op) ? rs_mag : rt_mag)};
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_CALC;
                    end else begin
                        if (bus.hi_we) begin
                            hi_q <= bus.wdata;
                        end
                        if (bus.lo_we) begin
                            lo_q <= bus.wdata;
                        end
                    end
                end
                ST_CALC: begin
                    acc <= op_is_div(op_q) ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    hi_q   <= hi_res;
                    lo_q   <= lo_res;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath, in the execute stage directly downstream of the register file. Takes the two register-file read operands (rs, rt), computes MULT/MULTU/DIV/DIVU over 32 iteration cycles, and holds the result in architectural HI/LO registers. HI/LO can also be written directly (MTHI/MTLO) and are read combinationally (MFHI/MFLO) by the writeback path into the register file.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; clears all state.
- start  input  1  request an operation; sampled only when busy=0.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- rs_val  input  WIDTH  operand A, multiplicand or dividend, from register-file dout1.
- rt_val  input  WIDTH  operand B, multiplier or divisor, from register-file dout2.
- hi_we  input  1  MTHI: write wdata into HI.
- lo_we  input  1  MTLO: write wdata into LO.
- wdata  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO receive a result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FINAL. 5-bit iteration counter.
- IDLE with start=1:
  - Latch op.
  - Signed ops: latch |rs_val|, |rt_val| and the result signs.
  - Clear the accumulator/partial remainder. Counter=0. Go to CALC.
- CALC: one iteration per cycle.
  - Multiply: shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring division on magnitudes; one quotient bit per cycle.
  - After counter=31, go to FINAL.
- FINAL: apply signs, write HI/LO, pulse done, go to IDLE.
  - Multiply: {hi,lo} = 64-bit product. Negate when the operand signs differ (signed only).
  - Divide: lo = quotient, truncated toward zero. hi = remainder, which takes the dividend's sign.
  - Divide by zero (either divide op): lo=0xFFFFFFFF, hi=rs_val as latched (original, not magnitude). No exception.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO: accepted only in IDLE with start=0. HI/LO update on the next edge.
  - start and hi_we/lo_we in the same IDLE cycle: start wins, the write is dropped.
  - hi_we/lo_we while busy: ignored.
- start while busy: ignored; no queuing.
- Operand latching: rs_val/rt_val are used only at the accepting edge. Later changes have no effect.

## Timing
- Reset (asserted low, asynchronous): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0. The internal accumulator is cleared.
- Reset asserted mid-operation: the operation is abandoned, HI/LO=0, and no done pulse is produced.
- The operation sequence, with start accepted at edge T:
  - busy=1 from edge T.
  - Iterations run on edges T+1..T+32.
  - FINAL runs on edge T+33: hi/lo take the result, done=1 for one cycle, busy=0.
  - The earliest next start is accepted at edge T+34.
- Latency from the accepting edge to result visibility is 33 cycles, fixed and data-independent.
- hi/lo are register outputs with no combinational path from inputs. They hold the old value throughout CALC.

## Structure
- Shared package mdu_pkg:
  - op encodings MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11.
  - state encoding.
  - MDU_ITER=32.
- One combinational sub-module is natural: mdu_sign_fix.
  - Takes magnitude results and the latched signs.
  - Produces final hi/lo, including the divide-by-zero override.
- The iteration datapath and FSM stay in mul_div_unit.

## Test plan
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; done one cycle; busy high exactly 33 cycles.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=7 -> lo=14, hi=2.
- DIVU rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Busy rules: start with new operands at cycle T+5 -> ignored, first result unchanged. hi_we during busy -> ignored. MTLO wdata=0xA5A5A5A5 in IDLE -> lo=0xA5A5A5A5 next cycle. start+lo_we in the same cycle -> only the op takes effect.
- Reset asserted at cycle T+10 of a MULT -> hi=lo=0, busy=0 immediately; no done. A new MULTU 6*7 after release -> lo=42, hi=0.
